// File: rtl/gbfact_loader_if.sv
// gbfact_loader_if: host beat stream into the activation loader
interface gbfact_loader_if #(parameter int BLOCK_DEPTH = 32);
  logic LOAD_Val;
  logic LOAD_IsFlg;
  logic [BLOCK_DEPTH-1:0] LOAD_Dat;
  logic LOAD_Rdy;
  modport master (output LOAD_Val, LOAD_IsFlg, LOAD_Dat, input LOAD_Rdy);
  modport slave (input LOAD_Val, LOAD_IsFlg, LOAD_Dat, output LOAD_Rdy);
endinterface

// File: rtl/gbfact_loader.sv
// gbfact_loader: writes compressed activation blocks (flag word + set-bit data) into the GBFACT/GBFFLGACT SRAMs
module gbfact_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_DEPTH = 32,
  parameter int GBFACT_ADDRWIDTH = 12,
  parameter int BLK_WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic LOAD_Sta,
  input  logic [BLK_WIDTH-1:0] CFG_NumBlk,
  gbfact_loader_if.slave ld,
  output logic GBFACT_EnWr,
  output logic [GBFACT_ADDRWIDTH-1:0] GBFACT_AddrWr,
  output logic [DATA_WIDTH-1:0] GBFACT_DatWr,
  output logic GBFFLGACT_EnWr,
  output logic [GBFACT_ADDRWIDTH-1:0] GBFFLGACT_AddrWr,
  output logic [BLOCK_DEPTH-1:0] GBFFLGACT_DatWr,
  output logic GBFACT_Val,
  output logic GBFFLGACT_Val,
  output logic LOAD_Busy,
  output logic LOAD_Err
);
  localparam int CW = $clog2(BLOCK_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, FLG, DAT, DONE} state_t;
  state_t state;
  logic [BLK_WIDTH-1:0] numBlk, blkCnt;
  logic [GBFACT_ADDRWIDTH-1:0] flgAddr, actAddr;
  logic [CW-1:0] remCnt, pop;
  logic acc, flgWr, actWr, bad, blkFin, lastBlk, start;
  assign ld.LOAD_Rdy = state == FLG || state == DAT;
  assign LOAD_Busy = ld.LOAD_Rdy;
  always_comb begin
    pop = '0;
    for (int i = 0; i < BLOCK_DEPTH; i++) pop = pop + CW'(ld.LOAD_Dat[i]);
    acc = ld.LOAD_Val && ld.LOAD_Rdy;
    flgWr = acc && state == FLG && ld.LOAD_IsFlg;
    actWr = acc && state == DAT && !ld.LOAD_IsFlg;
    bad = acc && !flgWr && !actWr;
    blkFin = (flgWr && pop == '0) || (actWr && remCnt == CW'(1));
    lastBlk = blkCnt + 1'b1 == numBlk;
    start = LOAD_Sta && (state == IDLE || state == DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      numBlk <= '0;
      blkCnt <= '0;
      flgAddr <= '0;
      actAddr <= '0;
      remCnt <= '0;
      GBFACT_EnWr <= 1'b0;
      GBFACT_AddrWr <= '0;
      GBFACT_DatWr <= '0;
      GBFFLGACT_EnWr <= 1'b0;
      GBFFLGACT_AddrWr <= '0;
      GBFFLGACT_DatWr <= '0;
      GBFACT_Val <= 1'b0;
      GBFFLGACT_Val <= 1'b0;
      LOAD_Err <= 1'b0;
    end else begin
      GBFFLGACT_EnWr <= flgWr;
      GBFACT_EnWr <= actWr;
      state <= start ? (CFG_NumBlk == '0 ? DONE : FLG) : blkFin ? (lastBlk ? DONE : FLG) : flgWr ? DAT : state;
      LOAD_Err <= !start && (LOAD_Err || bad || (flgWr && &flgAddr) || (actWr && &actAddr));
      if (start) begin
        numBlk <= CFG_NumBlk;
        blkCnt <= '0;
        flgAddr <= '0;
        actAddr <= '0;
        GBFACT_Val <= CFG_NumBlk == '0;
        GBFFLGACT_Val <= CFG_NumBlk == '0;
      end
      if (flgWr) begin
        GBFFLGACT_AddrWr <= flgAddr;
        GBFFLGACT_DatWr <= ld.LOAD_Dat;
        flgAddr <= flgAddr + 1'b1;
        remCnt <= pop;
      end
      if (actWr) begin
        GBFACT_AddrWr <= actAddr;
        GBFACT_DatWr <= ld.LOAD_Dat[DATA_WIDTH-1:0];
        actAddr <= actAddr + 1'b1;
        remCnt <= remCnt - 1'b1;
      end
      if (blkFin) blkCnt <= blkCnt + 1'b1;
      if (blkFin && lastBlk) begin
        GBFACT_Val <= 1'b1;
        GBFFLGACT_Val <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gbfact_loader.sv
// tb_gbfact_loader: directed beats with scoreboard queues checked by write monitors
module tb_gbfact_loader;
  logic clk = 0, rst_n = 0, sta = 0;
  logic [15:0] cfg = '0;
  int cyc = 0, checks = 0, errors = 0;
  bit en2 = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  gbfact_loader_if #(.BLOCK_DEPTH(32)) li();
  gbfact_loader_if #(.BLOCK_DEPTH(32)) li2();
  assign li2.LOAD_Val = li.LOAD_Val;
  assign li2.LOAD_IsFlg = li.LOAD_IsFlg;
  assign li2.LOAD_Dat = li.LOAD_Dat;
  logic aEn, fEn, aVal, fVal, busy, err;
  logic [11:0] aAddr, fAddr;
  logic [7:0] aDat;
  logic [31:0] fDat;
  logic aEn2, fEn2, aVal2, fVal2, busy2, err2;
  logic [1:0] aAddr2, fAddr2;
  logic [7:0] aDat2;
  logic [31:0] fDat2;
  gbfact_loader dut (.clk(clk), .rst_n(rst_n), .LOAD_Sta(sta), .CFG_NumBlk(cfg), .ld(li.slave),
    .GBFACT_EnWr(aEn), .GBFACT_AddrWr(aAddr), .GBFACT_DatWr(aDat), .GBFFLGACT_EnWr(fEn),
    .GBFFLGACT_AddrWr(fAddr), .GBFFLGACT_DatWr(fDat), .GBFACT_Val(aVal), .GBFFLGACT_Val(fVal),
    .LOAD_Busy(busy), .LOAD_Err(err));
  gbfact_loader #(.GBFACT_ADDRWIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .LOAD_Sta(sta), .CFG_NumBlk(cfg), .ld(li2.slave),
    .GBFACT_EnWr(aEn2), .GBFACT_AddrWr(aAddr2), .GBFACT_DatWr(aDat2), .GBFFLGACT_EnWr(fEn2),
    .GBFFLGACT_AddrWr(fAddr2), .GBFFLGACT_DatWr(fDat2), .GBFACT_Val(aVal2), .GBFFLGACT_Val(fVal2),
    .LOAD_Busy(busy2), .LOAD_Err(err2));
  typedef struct {logic [11:0] a; logic [31:0] d; int c;} exp_t;
  exp_t flgQ[$], actQ[$], flg2Q[$];
  typedef enum {NONE, FW, AW} wk_t;
  task automatic cmpw(input string n, input exp_t e, input logic [11:0] a, input logic [31:0] d);
    checks++;
    if (e.a !== a || e.d !== d || e.c != cyc) begin
      errors++;
      $display("FAIL %s: got addr=%0h dat=%0h cyc=%0d, want addr=%0h dat=%0h cyc=%0d", n, a, d, cyc, e.a, e.d, e.c);
    end
  endtask
  task automatic unexp(input string n);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected write at cyc=%0d, want none", n, cyc);
  endtask
  always @(negedge clk) if (fEn) begin
    if (flgQ.size() == 0) unexp("flg_wr");
    else cmpw("flg_wr", flgQ.pop_front(), fAddr, fDat);
  end
  always @(negedge clk) if (aEn) begin
    if (actQ.size() == 0) unexp("act_wr");
    else cmpw("act_wr", actQ.pop_front(), aAddr, {24'h0, aDat});
  end
  always @(negedge clk) if (en2 && fEn2) begin
    if (flg2Q.size() == 0) unexp("flg2_wr");
    else cmpw("flg2_wr", flg2Q.pop_front(), {10'h0, fAddr2}, fDat2);
  end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, got, want);
    end
  endtask
  task automatic beat(input logic f, input logic [31:0] d, input wk_t wk, input logic [11:0] a, input logic [1:0] a2);
    int n = 0;
    li.LOAD_Val = 1;
    li.LOAD_IsFlg = f;
    li.LOAD_Dat = d;
    while (!li.LOAD_Rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout: got Rdy=0 for 20 cycles, want 1");
    end
    if (wk == FW) flgQ.push_back('{a, d, cyc + 1});
    if (wk == AW) actQ.push_back('{a, {24'h0, d[7:0]}, cyc + 1});
    if (wk == FW && en2) flg2Q.push_back('{{10'h0, a2}, d, cyc + 1});
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    li.LOAD_Val = 0;
    repeat (n) @(negedge clk);
  endtask
  task automatic start(input logic [15:0] n);
    li.LOAD_Val = 0;
    sta = 1;
    cfg = n;
    @(negedge clk);
    sta = 0;
  endtask
  initial begin
    li.LOAD_Val = 0;
    li.LOAD_IsFlg = 0;
    li.LOAD_Dat = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", li.LOAD_Rdy, 0);
    chk("rst_outs", {aEn, fEn, aVal, fVal, busy, err}, 0);
    chk("rst_addr", {aAddr, fAddr, aDat}, 0);
    chk("rst_fdat", fDat, 0);
    rst_n = 1;
    @(negedge clk);
    start(1);
    chk("t1_busy", busy, 1);
    beat(1, 32'h5, FW, 0, 0);
    beat(0, 32'h11, AW, 0, 0);
    chk("t1_val_early", {aVal, fVal}, 0);
    beat(0, 32'h22, AW, 1, 0);
    chk("t1_val", {aVal, fVal, busy, li.LOAD_Rdy, err}, 5'b11000);
    start(2);
    chk("t2_val_clr", {aVal, fVal}, 0);
    beat(1, 32'h0, FW, 0, 0);
    beat(1, 32'h8000_0000, FW, 1, 0);
    beat(0, 32'h7F, AW, 0, 0);
    idle(1);
    chk("t2_done", {aVal, fVal, busy, err}, 4'b1100);
    start(1);
    beat(1, 32'hFFFF_FFFF, FW, 0, 0);
    for (int i = 0; i < 32; i++) begin
      beat(0, 32'(i * 3 + 1), AW, 12'(i), 0);
      if (i < 31) chk("t3_rdy", li.LOAD_Rdy, 1);
      idle(1);
    end
    chk("t3_done", {aVal, fVal, busy, err}, 4'b1100);
    start(1);
    beat(1, 32'h3, FW, 0, 0);
    beat(0, 32'hAA, AW, 0, 0);
    beat(1, 32'hFF, NONE, 0, 0);
    chk("t4_err", {err, aVal}, 2'b10);
    beat(0, 32'hBB, AW, 1, 0);
    chk("t4_done", {aVal, fVal, err}, 3'b111);
    start(1);
    chk("t4_clr", {aVal, fVal, err}, 0);
    beat(1, 32'h0, FW, 0, 0);
    chk("t4_zero_blk", {aVal, fVal}, 2'b11);
    start(0);
    chk("t5_numblk0", {aVal, fVal, busy}, 3'b110);
    en2 = 1;
    start(5);
    for (int i = 0; i < 5; i++) begin
      beat(1, 32'h0, FW, 12'(i), 2'(i));
      if (i == 2) chk("t5_err2_pre", err2, 0);
      if (i == 3) chk("t5_err2_wrap", err2, 1);
    end
    idle(1);
    chk("t5_done", {aVal2, fVal2, err2, aVal, fVal, err}, 6'b111110);
    en2 = 0;
    sta = 1;
    cfg = 1;
    li.LOAD_Val = 1;
    li.LOAD_IsFlg = 1;
    li.LOAD_Dat = 32'hF;
    @(negedge clk);
    sta = 0;
    chk("t6_sta_busy", busy, 1);
    beat(1, 32'hF, FW, 0, 0);
    beat(0, 32'h1, AW, 0, 0);
    li.LOAD_Dat = 32'h2;
    #2 rst_n = 0;
    #1 chk("t6_rst", {li.LOAD_Rdy, busy, aEn, fEn, aVal, fVal, err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("t6_after", {li.LOAD_Rdy, busy, aVal, fVal}, 0);
    idle(2);
    chk("q_flg_empty", flgQ.size(), 0);
    chk("q_act_empty", actQ.size(), 0);
    chk("q_flg2_empty", flg2Q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gbfact_loader.md
Name: gbfact_loader

Overview:
- Write-side producer for the activation global buffers (RAM_GBFACT and RAM_GBFFLGACT); DISACT is the read side of the same buffers.
- Accepts a host beat stream of compressed activation blocks. Each block is one sparsity flag word followed by one data beat per set flag bit.
- Generates write enables, addresses and data for both SRAMs.
- Raises the buffer-valid levels GBFACT_Val and GBFFLGACT_Val once the configured number of blocks is stored.

Parameters:
- DATA_WIDTH, 8, activation width.
- BLOCK_DEPTH, 32, flag bits per block (channels per block).
- GBFACT_ADDRWIDTH, 12, address width of both activation SRAMs.
- BLK_WIDTH, 16, width of the block-count configuration.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- LOAD_Sta  in  1  start pulse for a new load.
- CFG_NumBlk  in  BLK_WIDTH  blocks per load; sampled on an accepted LOAD_Sta.
- LOAD_Val  in  1  host beat valid.
- LOAD_IsFlg  in  1  beat is a flag word (1) or activation data (0).
- LOAD_Dat  in  BLOCK_DEPTH  beat payload; data beats use bits [DATA_WIDTH-1:0].
- LOAD_Rdy  out  1  loader accepts a beat this cycle.
- GBFACT_EnWr  out  1  activation SRAM write enable.
- GBFACT_AddrWr  out  GBFACT_ADDRWIDTH  activation write address.
- GBFACT_DatWr  out  DATA_WIDTH  activation write data.
- GBFFLGACT_EnWr  out  1  flag SRAM write enable.
- GBFFLGACT_AddrWr  out  GBFACT_ADDRWIDTH  flag write address.
- GBFFLGACT_DatWr  out  BLOCK_DEPTH  flag write data.
- GBFACT_Val  out  1  activation buffer holds a complete load.
- GBFFLGACT_Val  out  1  flag buffer holds a complete load.
- LOAD_Busy  out  1  load in progress.
- LOAD_Err  out  1  sticky protocol/overflow error.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0.
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- FSM states: IDLE, FLG, DAT, DONE.
- LOAD_Rdy is combinational: 1 exactly in FLG and DAT.
- A beat is accepted when LOAD_Val && LOAD_Rdy.
- LOAD_Sta in IDLE or DONE:
  - clears both Val outputs, LOAD_Err, block counter, flag address and activation address;
  - latches CFG_NumBlk;
  - next state is FLG, or DONE if CFG_NumBlk==0;
  - LOAD_Busy=1 while in FLG or DAT.
- LOAD_Sta in FLG or DAT: ignored; the load continues.
- FLG state, accepted beat with LOAD_IsFlg=1:
  - next cycle: GBFFLGACT_EnWr=1, AddrWr = flag address, DatWr = LOAD_Dat;
  - flag address increments;
  - remaining-data counter loads popcount(LOAD_Dat), range 0..BLOCK_DEPTH.
  - popcount 0 → block complete immediately, no DAT state.
  - popcount >0 → DAT.
- DAT state, accepted beat with LOAD_IsFlg=0:
  - next cycle: GBFACT_EnWr=1, AddrWr = activation address, DatWr = LOAD_Dat[DATA_WIDTH-1:0];
  - activation address increments, remaining count decrements;
  - on the last beat the block is complete.
- Block complete: block counter increments. If it equals the latched NumBlk → DONE; otherwise → FLG.
- Entering DONE: GBFACT_Val and GBFFLGACT_Val go 1 on the same edge and hold until the next accepted LOAD_Sta or reset. LOAD_Busy=0.
- Write latency: exactly 1 cycle from beat acceptance to EnWr. EnWr is never 1 without an accepted beat. Back-to-back beats give back-to-back writes.
- Type mismatch (IsFlg=1 in DAT, or IsFlg=0 in FLG): beat is consumed and dropped, no write, LOAD_Err set, state unchanged.
- Address overflow: an accepted write when the address is all-ones performs the write, wraps the address to 0, and sets LOAD_Err.
- LOAD_Err is sticky; cleared only by an accepted LOAD_Sta or reset.
- Simultaneous LOAD_Sta and LOAD_Val in IDLE/DONE: the beat is not accepted (Rdy=0); the start takes effect.
- Reset mid-load: immediate return to IDLE, outputs 0. The SRAM content is left as written; Val stays 0.

Test Plan:
- Reset → all outputs 0.
- LOAD_Sta with NumBlk=1. Stream flag 32'h0000_0005, data 8'h11, 8'h22 → flag write at addr 0, data 0x005; act writes (0,0x11), (1,0x22); both Val=1 one edge after last beat; Busy=0.
- NumBlk=2, first flag 32'h0 then flag 32'h8000_0000 + data 8'h7F:
  - flag writes at addr 0 and 1; act write (0,0x7F); Val=1;
  - no DAT cycles for the zero block.
- Full block, flag 32'hFFFF_FFFF + 32 data beats with LOAD_Val toggling every other cycle:
  - 32 act writes at addrs 0..31, each exactly 1 cycle after its accept; Rdy high throughout.
- In DAT, send beat with IsFlg=1 → no write, LOAD_Err=1, the remaining data still completes the block; next LOAD_Sta clears Err and Val.
- Addr width forced to 2, NumBlk=5 of zero flags → flag addrs 0,1,2,3,0; Err=1 on the 4th write; Val=1 at end.
- Assert rst_n low mid-DAT → immediate IDLE, Rdy=0, no further writes.
